// File: rtl/freq_calc.sv
// freq_calc: converts a raw clock-cycle count for a window of (times+1)
// input periods into a frequency in Hz:
//   freq = CLK_HZ*(times+1)/(cnt_in+1)
// The division is a 64-by-33-bit serial restoring divider, one quotient
// bit per clock, MSB first.
// Optional build macro FREQ_CALC_ROUND_EN: round the quotient to nearest
// (ties up) instead of truncating. Latency is the same in both builds.
module freq_calc #(
  parameter int unsigned CLK_HZ = 125_000_000,  // must be < 2^31
  parameter int unsigned QW     = 32            // freq_out width, < 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [31:0]   cnt_in,
  input  logic [31:0]   times,
  output logic [QW-1:0] freq_out,
  output logic          freq_valid,
  output logic          busy,
  output logic          no_sig,
  output logic          sat
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [63:0] CLK_HZ_64 = 64'(CLK_HZ);

  state_t      state;
  state_t      state_nx;

  logic [31:0] cnt_r;      // captured cycle count
  logic [31:0] times_r;    // captured window selector
  logic [63:0] dividend;   // shifted left one bit per iteration
  logic [32:0] divisor;
  logic [32:0] rem;
  logic [63:0] quo;        // quotient bits shifted in from the right
  logic [5:0]  iter;
  logic        zero_r;     // captured cnt_in was zero

  // Operands prepared for LOAD; 33-bit adds keep 0xFFFFFFFF+1 from wrapping.
  logic [32:0] div_load;
  logic [32:0] window;
  logic [63:0] dividend_load;

  // One restoring-division step.
  logic [33:0] rem_sh;
  logic        sub_ok;
  logic [32:0] rem_sub;

  // Operand preparation and the combinational divider step.
  always_comb begin
    div_load      = {1'b0, cnt_r} + 33'd1;
    window        = {1'b0, times_r} + 33'd1;
    // CLK_HZ < 2^31 and window <= 2^32, so the product fits in 63 bits.
    dividend_load = CLK_HZ_64 * {31'd0, window};
`ifdef FREQ_CALC_ROUND_EN
    dividend_load = dividend_load + {32'd0, div_load[32:1]};
`endif
    rem_sh  = {rem, dividend[63]};
    sub_ok  = (rem_sh >= {1'b0, divisor});
    // The remainder after a successful subtract is < divisor, so the
    // low 33 bits of the difference are exact.
    rem_sub = rem_sh[32:0] - divisor;
  end

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (en) state_nx = S_LOAD;
      S_LOAD: state_nx = (cnt_r == 32'd0) ? S_DONE : S_DIV;
      S_DIV:  if (iter == 6'd0) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Datapath: capture, load, divide, publish.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r      <= '0;
      times_r    <= '0;
      dividend   <= '0;
      divisor    <= '0;
      rem        <= '0;
      quo        <= '0;
      iter       <= '0;
      zero_r     <= 1'b0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
      no_sig     <= 1'b0;
      sat        <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            cnt_r   <= cnt_in;
            times_r <= times;
          end
        end
        S_LOAD: begin
          dividend <= dividend_load;
          divisor  <= div_load;
          quo      <= '0;
          rem      <= '0;
          iter     <= 6'd63;
          zero_r   <= (cnt_r == 32'd0);
        end
        S_DIV: begin
          rem      <= sub_ok ? rem_sub : rem_sh[32:0];
          quo      <= {quo[62:0], sub_ok};
          dividend <= {dividend[62:0], 1'b0};
          iter     <= iter - 6'd1;
        end
        S_DONE: begin
          if ((quo >> QW) != 64'd0) begin
            freq_out <= '1;
            sat      <= 1'b1;
          end else begin
            freq_out <= quo[QW-1:0];
            sat      <= 1'b0;
          end
          no_sig     <= zero_r;
          freq_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_calc.sv
// Self-checking bench for freq_calc (default parameters, CLK_HZ=125 MHz, QW=32).
// Expected values come from a plain-arithmetic model of
//   freq = CLK_HZ*(times+1)/(cnt_in+1)
// with saturation, no-signal and optional rounding (FREQ_CALC_ROUND_EN).
module tb_freq_calc;

  localparam int unsigned CLK_HZ = 125_000_000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [31:0] cnt_in = '0;
  logic [31:0] times = '0;
  logic [31:0] freq_out;
  logic        freq_valid;
  logic        busy;
  logic        no_sig;
  logic        sat;

  int vectors = 0;
  int errors  = 0;

  freq_calc #(.CLK_HZ(CLK_HZ), .QW(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .cnt_in     (cnt_in),
    .times      (times),
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .busy       (busy),
    .no_sig     (no_sig),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  // Reference model: exact integer arithmetic on 64-bit values.
  function automatic void model(input logic [31:0] c, input logic [31:0] t,
                                output logic [31:0] f, output logic s,
                                output logic n);
    longint unsigned num, den, q;
    if (c == 32'd0) begin
      f = 32'd0; s = 1'b0; n = 1'b1;
      return;
    end
    num = longint'(CLK_HZ) * (longint'(t) + 64'd1);
    den = longint'(c) + 64'd1;
`ifdef FREQ_CALC_ROUND_EN
    num = num + den / 64'd2;
`endif
    q = num / den;
    n = 1'b0;
    if (q > 64'hFFFF_FFFF) begin
      f = 32'hFFFF_FFFF; s = 1'b1;
    end else begin
      f = q[31:0]; s = 1'b0;
    end
  endfunction

  // One isolated measurement from IDLE. Returns the edge count from capture
  // to freq_valid (-1 on timeout), the number of post-edge samples with busy
  // high before freq_valid (edge 0 included), and busy at the valid cycle.
  // Inputs are scrambled right after capture to show they are ignored.
  task automatic run_meas(input logic [31:0] c, input logic [31:0] t,
                          output int lat, output int busy_cnt,
                          output logic busy_end);
    lat = -1; busy_cnt = 0; busy_end = 1'bx;
    @(negedge clk);
    en = 1'b1; cnt_in = c; times = t;
    @(posedge clk); #1;
    if (busy) busy_cnt++;
    en = 1'b0; cnt_in = $urandom; times = $urandom;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (freq_valid) begin
        lat = k; busy_end = busy;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  // Run one measurement and compare every result field with the model.
  task automatic check_meas(input string name, input logic [31:0] c,
                            input logic [31:0] t);
    int lat, bc, exp_lat;
    logic be;
    logic [31:0] ef;
    logic es, en_s;
    model(c, t, ef, es, en_s);
    exp_lat = (c == 32'd0) ? 2 : 66;
    run_meas(c, t, lat, bc, be);
    vectors++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    vectors++;
    if (freq_out !== ef) begin
      errors++;
      $display("FAIL %s freq_out: got %0d expected %0d (cnt=%0d times=%0d)",
               name, freq_out, ef, c, t);
    end
    vectors++;
    if (sat !== es || no_sig !== en_s) begin
      errors++;
      $display("FAIL %s flags: got sat=%b no_sig=%b expected sat=%b no_sig=%b",
               name, sat, no_sig, es, en_s);
    end
    vectors++;
    if (bc !== exp_lat || be !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: got %0d busy cycles end=%b expected %0d end=0",
               name, bc, be, exp_lat);
    end
    // freq_valid must drop after one cycle
    @(posedge clk); #1;
    vectors++;
    if (freq_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_pulse: got %b expected 0", name, freq_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({freq_out, freq_valid, busy, no_sig, sat} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got freq=%0d v=%b b=%b n=%b s=%b expected all 0",
               freq_out, freq_valid, busy, no_sig, sat);
    end
    @(negedge clk); rstn = 1'b1;
    // with en low the block stays idle and outputs hold
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if ({freq_out, freq_valid, busy, no_sig, sat} !== 36'd0) begin
      errors++;
      $display("FAIL idle_hold: got freq=%0d v=%b b=%b expected all 0",
               freq_out, freq_valid, busy);
    end
  endtask

  task automatic test_basic();
    check_meas("basic_100k", 32'd12499, 32'd9);
    check_meas("div3", 32'd2, 32'd0);
  endtask

  task automatic test_no_sig();
    check_meas("no_sig", 32'd0, 32'd5);
    check_meas("no_sig_clear", 32'd12499, 32'd9);
  endtask

  task automatic test_saturation();
    check_meas("sat_big", 32'd1, 32'hFFFF_FFFF);
    check_meas("max_div", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_meas("sat_clear", 32'd124, 32'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [31:0] c, t;
      c = (i % 4 == 0) ? $urandom : $urandom_range(1, 2_000_000);
      t = (i % 5 == 0) ? $urandom : $urandom_range(0, 255);
      check_meas($sformatf("rand%0d", i), c, t);
    end
  endtask

  // en held high: captures land every 67 edges; the results must match the
  // inputs present at each capture edge even though they change every 10.
  task automatic test_back_to_back();
    logic [31:0] qf[$];
    logic [31:0] ef, f_exp;
    logic es, ens, prev_v;
    int seen;
    prev_v = 1'b0; seen = 0;
    @(negedge clk);
    en = 1'b1;
    for (int e = 0; e < 4 * 67; e++) begin
      if (e % 10 == 0) begin
        cnt_in = $urandom_range(1, 3_000_000);
        times  = $urandom_range(0, 63);
      end
      if (e % 67 == 0) begin
        model(cnt_in, times, ef, es, ens);
        qf.push_back(ef);
      end
      @(posedge clk); #1;
      if (e == 4 * 67 - 1) en = 1'b0;
      if (prev_v && freq_valid) begin
        errors++;
        $display("FAIL b2b_double_valid at edge %0d", e);
      end
      prev_v = freq_valid;
      if ((e % 67 == 66) || freq_valid) begin
        vectors++;
        if (freq_valid !== (e % 67 == 66)) begin
          errors++;
          $display("FAIL b2b_cadence edge %0d: got valid=%b expected %b",
                   e, freq_valid, (e % 67 == 66));
        end else begin
          seen++;
          f_exp = qf.pop_front();
          vectors++;
          if (freq_out !== f_exp) begin
            errors++;
            $display("FAIL b2b_result %0d: got %0d expected %0d", seen, freq_out, f_exp);
          end
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (seen !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results expected 4", seen);
    end
  endtask

  task automatic test_reset_mid();
    int vcount;
    vcount = 0;
    @(negedge clk);
    en = 1'b1; cnt_in = 32'd12499; times = 32'd9;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    vectors++;
    if ({freq_out, freq_valid, busy, no_sig, sat} !== 36'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got freq=%0d v=%b b=%b n=%b s=%b expected all 0",
               freq_out, freq_valid, busy, no_sig, sat);
    end
    @(negedge clk); rstn = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (freq_valid || busy) vcount++;
    end
    vectors++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", vcount);
    end
    check_meas("after_reset", 32'd12499, 32'd9);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_sig();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
